// File: rtl/jk_bank.sv
// jk_bank: a bank of WIDTH independent JK flip-flops that all update together
// on a divided-rate tick from one shared prescaler.
//
// J/K levels are OR-accumulated every cycle into per-bit request latches, so a
// short pulse from a button or switch between updates still reaches the next
// update. A synchronous parallel load overrides the JK result.
//
// Ports:
//   clk   system clock; all state changes on its rising edge
//   rst   synchronous reset, active-high (highest priority)
//   en    prescaler enable; low freezes the counter and suppresses ticks
//   J     per-channel set request (level, sampled every cycle)
//   K     per-channel reset request (level, sampled every cycle)
//   load  synchronous parallel load strobe (priority over an update)
//   D     parallel load data
//   Q     flip-flop state (registered)
//   Qn    ~Q (combinational)
//   tick  registered one-cycle pulse marking each bank update
module jk_bank #(
    parameter int                 WIDTH   = 4,
    parameter int                 DIV     = 50_000_000,
    parameter logic [WIDTH-1:0]   RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    input  logic             load,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn,
    output logic             tick
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] pj_reg;
    logic [WIDTH-1:0] pk_reg;
    logic [WIDTH-1:0] q_reg;
    logic             tick_reg;

    logic             update;
    logic [WIDTH-1:0] je;
    logic [WIDTH-1:0] ke;
    logic [WIDTH-1:0] q_next;

    // An update edge needs the counter at its last value with en high; with en
    // low the counter parks at DIV-1 and the update fires on the first enabled edge.
    assign update = en && (cnt_reg == CNT_MAX);

    // The current-cycle J/K are folded in so a pulse on the update edge counts.
    assign je = pj_reg | J;
    assign ke = pk_reg | K;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_jk
            always_comb begin
                q_next[gi] = q_reg[gi];
                unique case ({je[gi], ke[gi]})
                    2'b10:   q_next[gi] = 1'b1;
                    2'b01:   q_next[gi] = 1'b0;
                    2'b11:   q_next[gi] = ~q_reg[gi];
                    default: q_next[gi] = q_reg[gi];
                endcase
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg  <= '0;
            pj_reg   <= '0;
            pk_reg   <= '0;
            q_reg    <= RST_VAL;
            tick_reg <= 1'b0;
        end else begin
            if (en) begin
                cnt_reg <= update ? '0 : cnt_reg + CW'(1);
            end
            // tick marks the update edge even when a load overrides the JK result.
            tick_reg <= update;

            if (load) begin
                q_reg  <= D;
                pj_reg <= '0;
                pk_reg <= '0;
            end else if (update) begin
                q_reg  <= q_next;
                pj_reg <= '0;
                pk_reg <= '0;
            end else begin
                pj_reg <= je;
                pk_reg <= ke;
            end
        end
    end

    assign Q    = q_reg;
    assign Qn   = ~q_reg;
    assign tick = tick_reg;

endmodule

// File: tb/tb_jk_bank.sv
module tb_jk_bank;

    localparam int         WIDTH   = 4;
    localparam int         DIV     = 4;
    localparam logic [3:0] RST_VAL = 4'b1010;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [WIDTH-1:0] J;
    logic [WIDTH-1:0] K;
    logic             load;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] Qn;
    logic             tick;

    int checks = 0;
    int errors = 0;

    jk_bank #(.WIDTH(WIDTH), .DIV(DIV), .RST_VAL(RST_VAL)) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .J   (J),
        .K   (K),
        .load(load),
        .D   (D),
        .Q   (Q),
        .Qn  (Qn),
        .tick(tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic       load;
        logic [3:0] j;
        logic [3:0] k;
        logic [3:0] d;
        logic [3:0] exp_q;
        logic       exp_tick;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic e, input logic l,
                       input logic [3:0] j, input logic [3:0] k, input logic [3:0] d,
                       input logic [3:0] q, input logic t);
        vec_t v;
        v.rst = r; v.en = e; v.load = l; v.j = j; v.k = k; v.d = d;
        v.exp_q = q; v.exp_tick = t;
        vecs.push_back(v);
    endtask

    // Plain enabled cycles with no requests: n copies of the same expectation.
    task automatic idle(input int n, input logic [3:0] q, input logic t);
        for (int i = 0; i < n; i++) add(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, q, t);
    endtask

    task automatic check_outputs(input string name, input logic [3:0] eq, input logic et);
        checks++;
        if (Q !== eq) begin
            errors++;
            $display("FAIL %s Q got %b want %b", name, Q, eq);
        end
        checks++;
        if (Qn !== ~eq) begin
            errors++;
            $display("FAIL %s Qn got %b want %b", name, Qn, ~eq);
        end
        checks++;
        if (tick !== et) begin
            errors++;
            $display("FAIL %s tick got %b want %b", name, tick, et);
        end
    endtask

    initial begin
        int edges;
        bit seen;

        rst = 1'b1; en = 1'b1; J = '0; K = '0; load = 1'b0; D = '0;

        // Reset, then three free-running periods: tick on edges 4, 8, 12.
        add(1, 1, 0, 4'h0, 4'h0, 4'h0, 4'b1010, 0);
        add(1, 1, 0, 4'h0, 4'h0, 4'h0, 4'b1010, 0);
        for (int p = 0; p < 3; p++) begin
            idle(3, 4'b1010, 0);
            idle(1, 4'b1010, 1);
        end
        // Load 0000 off an update edge, then set/reset/toggle with J=0011 K=0101.
        add(0, 1, 1, 4'h0, 4'h0, 4'b0000, 4'b0000, 0);
        add(0, 1, 0, 4'b0011, 4'b0101, 4'h0, 4'b0000, 0);
        add(0, 1, 0, 4'b0011, 4'b0101, 4'h0, 4'b0000, 0);
        add(0, 1, 0, 4'b0011, 4'b0101, 4'h0, 4'b0011, 1);
        add(0, 1, 0, 4'b0011, 4'b0101, 4'h0, 4'b0011, 0);
        add(0, 1, 0, 4'b0011, 4'b0101, 4'h0, 4'b0011, 0);
        add(0, 1, 0, 4'b0011, 4'b0101, 4'h0, 4'b0011, 0);
        add(0, 1, 0, 4'b0011, 4'b0101, 4'h0, 4'b0010, 1);
        // One-cycle J[3] pulse alone -> set.
        idle(1, 4'b0010, 0);
        add(0, 1, 0, 4'b1000, 4'h0, 4'h0, 4'b0010, 0);
        idle(1, 4'b0010, 0);
        idle(1, 4'b1010, 1);
        // J[3] then K[3] in different cycles -> toggle.
        idle(1, 4'b1010, 0);
        add(0, 1, 0, 4'b1000, 4'h0, 4'h0, 4'b1010, 0);
        add(0, 1, 0, 4'h0, 4'b1000, 4'h0, 4'b1010, 0);
        idle(1, 4'b0010, 1);
        // Latches cleared: next tick holds.
        idle(3, 4'b0010, 0);
        idle(1, 4'b0010, 1);
        // J[0] only on the update edge itself counts.
        idle(3, 4'b0010, 0);
        add(0, 1, 0, 4'b0001, 4'h0, 4'h0, 4'b0011, 1);
        // Freeze at cnt=2 for 10 cycles with a J=1111 pulse during the freeze.
        idle(2, 4'b0011, 0);
        for (int i = 0; i < 10; i++)
            add(0, 0, 0, (i == 3) ? 4'b1111 : 4'h0, 4'h0, 4'h0, 4'b0011, 0);
        idle(1, 4'b0011, 0);
        idle(1, 4'b1111, 1);
        // en low on the would-be update edge delays the update by one edge.
        add(0, 1, 0, 4'h0, 4'b1111, 4'h0, 4'b1111, 0);
        idle(2, 4'b1111, 0);
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'b1111, 0);
        idle(1, 4'b0000, 1);
        // Load on an update edge wins over J=1111 but tick still pulses.
        idle(1, 4'b0000, 0);
        add(0, 1, 0, 4'b1111, 4'h0, 4'h0, 4'b0000, 0);
        idle(1, 4'b0000, 0);
        add(0, 1, 1, 4'b1111, 4'h0, 4'b0110, 4'b0110, 1);
        idle(3, 4'b0110, 0);
        idle(1, 4'b0110, 1);
        // Reset at cnt=2 with pending J[0]: request lost, full period after release.
        idle(1, 4'b0110, 0);
        add(0, 1, 0, 4'b0001, 4'h0, 4'h0, 4'b0110, 0);
        add(1, 1, 0, 4'h0, 4'h0, 4'h0, 4'b1010, 0);
        idle(3, 4'b1010, 0);
        idle(1, 4'b1010, 1);

        // Inputs change only after #1 following a rising edge; outputs are
        // sampled at the same point.
        foreach (vecs[i]) begin
            rst = vecs[i].rst; en = vecs[i].en; load = vecs[i].load;
            J = vecs[i].j; K = vecs[i].k; D = vecs[i].d;
            @(posedge clk);
            #1;
            check_outputs($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_tick);
            $display("vec %0d rst=%b en=%b load=%b J=%b K=%b D=%b -> Q=%b tick=%b",
                     i, vecs[i].rst, vecs[i].en, vecs[i].load, vecs[i].j, vecs[i].k,
                     vecs[i].d, Q, tick);
        end

        // Reset overrides load and J: Q returns to RST_VAL.
        rst = 1'b1; en = 1'b1; load = 1'b1; D = 4'b0101; J = 4'b1111; K = '0;
        @(posedge clk);
        #1;
        check_outputs("rst_over_load", 4'b1010, 1'b0);
        $display("seq rst_over_load -> Q=%b tick=%b", Q, tick);

        // Count edges to the first tick after release, bounded.
        rst = 1'b0; load = 1'b0; J = '0;
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
            if (tick) seen = 1'b1;
        end
        checks++;
        if (!seen || edges != DIV) begin
            errors++;
            $display("FAIL first_tick_latency got %0d edges (seen=%b) want %0d", edges, seen, DIV);
        end
        $display("seq first_tick_latency -> %0d edges", edges);

        // en low for a long stretch: no tick may appear.
        en = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (tick) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL freeze_no_tick got tick during en=0 want none");
        end
        $display("seq freeze_no_tick -> seen=%b", seen);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
